// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: round-robin arbiter feeding one two-phase dual-rail async link.
// Each accepted word toggles exactly one rail per bit; the next word waits for
// the synchronized receiver ack to settle to the current token parity.
module link_tx_arbiter #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned REQ_NUM     = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024,
  localparam int unsigned GW         = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_NUM-1:0]              req_valid_i,
  input  logic [REQ_NUM-1:0][WIDTH-1:0]   req_data_i,
  output logic [REQ_NUM-1:0]              req_ready_o,
  output logic [WIDTH-1:0][1:0]           out,
  input  logic                            ack_i,
  output logic                            busy_o,
  output logic [GW-1:0]                   grant_o,
  output logic                            timeout_o,
  output logic                            proto_err_o
);

  localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam bit            TO_EN   = (TIMEOUT != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0][1:0]   out_d;
  logic                    timeout_d;
  logic                    proto_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_s;
  logic                    found;
  logic [GW-1:0]           sel_idx;
  logic [WIDTH-1:0]        sel_data;
  logic [REQ_NUM-1:0]      ready_oh;

  // Ack synchronizer: ack_i is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    int j;
    found    = 1'b0;
    sel_idx  = '0;
    j        = 0;
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      j = int'(ptr_q) + i;
      if (j >= int'(REQ_NUM)) j = j - int'(REQ_NUM);
      if (!found && req_valid_i[j]) begin
        found   = 1'b1;
        sel_idx = GW'(j);
      end
    end
    sel_data          = req_data_i[sel_idx];
    ready_oh          = '0;
    ready_oh[sel_idx] = found;
  end

  // Ready is only offered in IDLE and is forced low while reset is asserted.
  assign req_ready_o = (state_q == S_IDLE && !rst) ? ready_oh : '0;

  // Next-state and next-value logic for the link FSM.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ptr_d     = ptr_q;
    grant_d   = grant_o;
    cnt_d     = cnt_q;
    out_d     = out;
    timeout_d = timeout_o;
    proto_d   = proto_err_o;
    case (state_q)
      S_IDLE: begin
        // No token outstanding, so the ack must already match our parity.
        if (ack_s != phase_q) proto_d = 1'b1;
        if (found) begin
          for (int b = 0; b < int'(WIDTH); b++) begin
            if (sel_data[b]) out_d[b][1] = ~out[b][1];
            else             out_d[b][0] = ~out[b][0];
          end
          phase_d = ~phase_q;
          grant_d = sel_idx;
          ptr_d   = (sel_idx == GW'(REQ_NUM - 1)) ? '0 : sel_idx + 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_s == phase_q) begin
          state_d = S_IDLE;
        end else if (TO_EN && cnt_q != TO_MAX) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TO_LAST) timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Link rails, parity, pointer, counters and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out         <= '0;
      phase_q     <= 1'b0;
      ptr_q       <= '0;
      grant_o     <= '0;
      cnt_q       <= '0;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      out         <= out_d;
      phase_q     <= phase_d;
      ptr_q       <= ptr_d;
      grant_o     <= grant_d;
      cnt_q       <= cnt_d;
      timeout_o   <= timeout_d;
      proto_err_o <= proto_d;
      busy_o      <= (state_d == S_WAIT);
    end
  end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: single-requester loopback plus a three-requester
// instance covering round-robin order, timeout, protocol error and reset.
module tb_link_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Single-requester instance with loopback receiver, timeout disabled
  logic              valid1 = 1'b0;
  logic [0:0][3:0]   data1  = '0;
  logic [0:0]        ready1;
  logic [3:0][1:0]   out1;
  logic              ack1;
  logic              busy1;
  logic [0:0]        grant1;
  logic              timeout1;
  logic              proto1;

  // Three-requester instance, ack from loopback or forced by the bench
  logic [2:0]        valid3 = '0;
  logic [2:0][3:0]   data3  = '0;
  logic [2:0]        ready3;
  logic [3:0][1:0]   out3;
  logic              ack3;
  logic              busy3;
  logic [1:0]        grant3;
  logic              timeout3;
  logic              proto3;

  link_tx_arbiter #(.WIDTH(4), .REQ_NUM(1), .SYNC_STAGES(2), .TIMEOUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid_i(valid1), .req_data_i(data1),
    .req_ready_o(ready1), .out(out1), .ack_i(ack1), .busy_o(busy1),
    .grant_o(grant1), .timeout_o(timeout1), .proto_err_o(proto1)
  );

  link_tx_arbiter #(.WIDTH(4), .REQ_NUM(3), .SYNC_STAGES(2), .TIMEOUT(16)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid_i(valid3), .req_data_i(data3),
    .req_ready_o(ready3), .out(out3), .ack_i(ack3), .busy_o(busy3),
    .grant_o(grant3), .timeout_o(timeout3), .proto_err_o(proto3)
  );

  function automatic logic [3:0] rail_xor(input logic [3:0][1:0] o);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = o[b][0] ^ o[b][1];
    return r;
  endfunction

  function automatic logic [3:0] decode(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) d[i] = a[2*i+1] ^ b[2*i+1];
    return d;
  endfunction

  function automatic logic [3:0] one_rail(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) d[i] = (a[2*i] ^ b[2*i]) ^ (a[2*i+1] ^ b[2*i+1]);
    return d;
  endfunction

  // Receiver models: per-bit XOR into a C-element, ack delayed 100 time units
  logic rcv1 = 1'b0;
  logic rcv3 = 1'b0;
  logic ack3_loop;
  logic force_mode = 1'b0;
  logic force_val  = 1'b0;

  always @(out1 or rst) begin
    if (rst)                        rcv1 = 1'b0;
    else if (rail_xor(out1) == 4'hF) rcv1 = 1'b1;
    else if (rail_xor(out1) == 4'h0) rcv1 = 1'b0;
  end

  always @(out3 or rst) begin
    if (rst)                        rcv3 = 1'b0;
    else if (rail_xor(out3) == 4'hF) rcv3 = 1'b1;
    else if (rail_xor(out3) == 4'h0) rcv3 = 1'b0;
  end

  assign #100 ack1      = rcv1;
  assign #100 ack3_loop = rcv3;
  assign ack3 = force_mode ? force_val : ack3_loop;

  int n_chk = 0;
  int n_bad = 0;
  int rdy_cnt[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One token on the three-requester instance, starting just after a negedge
  task automatic do_token(input int exp_idx, input bit wait_done, input string tag);
    int         n;
    logic [7:0] o0, o1;
    logic [2:0] oh;
    #1;
    n = 0;
    while (ready3 == 3'b000 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    oh = 3'(1 << exp_idx);
    chk({tag, "_rdy"}, 64'(ready3), 64'(oh));
    for (int k = 0; k < 3; k++) if (ready3[k]) rdy_cnt[k]++;
    o0 = out3;
    @(posedge clk);
    @(negedge clk);
    o1 = out3;
    chk({tag, "_grant"}, 64'(grant3), 64'(exp_idx));
    chk({tag, "_busy"}, 64'(busy3), 64'(1));
    chk({tag, "_data"}, 64'(decode(o0, o1)), 64'(data3[exp_idx]));
    chk({tag, "_onerail"}, 64'(one_rail(o0, o1)), 64'(4'hF));
    if (wait_done) begin
      n = 0;
      while (busy3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_done"}, 64'(busy3), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev;
    int         n;
    int         r1_before;

    for (int k = 0; k < 3; k++) rdy_cnt[k] = 0;
    valid1 = 1'b1;
    valid3 = 3'b111;
    #150;
    // Reset values with requesters valid
    chk("rst_ready1", 64'(ready1), 64'(0));
    chk("rst_ready3", 64'(ready3), 64'(0));
    chk("rst_out1", 64'(out1), 64'(0));
    chk("rst_out3", 64'(out3), 64'(0));
    chk("rst_busy3", 64'(busy3), 64'(0));
    chk("rst_grant3", 64'(grant3), 64'(0));
    chk("rst_flags3", 64'({timeout3, proto3}), 64'(0));
    valid1 = 1'b0;
    valid3 = 3'b000;
    @(negedge clk);
    rst = 1'b0;

    // Single requester, loopback: 4'hA twice
    @(negedge clk);
    valid1   = 1'b1;
    data1[0] = 4'hA;
    #1;
    chk("t1_rdy", 64'(ready1), 64'(1));
    prev = out1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    chk("t1_out", 64'(out1), 64'(8'h99));
    chk("t1_busy", 64'(busy1), 64'(1));
    chk("t1_grant", 64'(grant1), 64'(0));
    chk("t1_dec", 64'(decode(prev, out1)), 64'(4'hA));
    n = 0;
    while (busy1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_gap", 64'(busy1), 64'(0));
    valid1 = 1'b1;
    #1;
    chk("t2_rdy", 64'(ready1), 64'(1));
    prev = out1;
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    chk("t2_out", 64'(out1), 64'(0));
    chk("t2_dec", 64'(decode(prev, out1)), 64'(4'hA));
    n = 0;
    while (busy1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t2_done", 64'(busy1), 64'(0));
    chk("t1_flags", 64'({timeout1, proto1}), 64'(0));

    // Round robin with all three valid continuously
    data3[0] = 4'h1;
    data3[1] = 4'h6;
    data3[2] = 4'hC;
    valid3   = 3'b111;
    for (int t = 0; t < 9; t++) do_token(t % 3, 1'b1, $sformatf("rr%0d", t));
    valid3 = 3'b000;
    chk("rr_cnt0", 64'(rdy_cnt[0]), 64'(3));
    chk("rr_cnt1", 64'(rdy_cnt[1]), 64'(3));
    chk("rr_cnt2", 64'(rdy_cnt[2]), 64'(3));

    // Move pointer to 1, then only requesters 0 and 2 valid
    valid3 = 3'b001;
    do_token(0, 1'b1, "ptr1");
    r1_before = rdy_cnt[1];
    valid3 = 3'b101;
    do_token(2, 1'b1, "sk0");
    do_token(0, 1'b1, "sk1");
    do_token(2, 1'b1, "sk2");
    valid3 = 3'b000;
    chk("skip_r1", 64'(rdy_cnt[1]), 64'(r1_before));

    // Timeout with ack held constant
    @(negedge clk);
    force_val  = ack3_loop;
    force_mode = 1'b1;
    valid3     = 3'b001;
    do_token(0, 1'b0, "to");
    valid3 = 3'b000;
    repeat (15) @(negedge clk);
    chk("to_15", 64'(timeout3), 64'(0));
    @(negedge clk);
    chk("to_16", 64'(timeout3), 64'(1));
    chk("to_busy", 64'(busy3), 64'(1));
    force_val = ~force_val;
    n = 0;
    while (busy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_late_ack", 64'(busy3), 64'(0));
    chk("to_sticky", 64'(timeout3), 64'(1));

    // Protocol error: ack high while idle with phase 0
    chk("pe_pre", 64'(proto3), 64'(0));
    force_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pe_2", 64'(proto3), 64'(0));
    @(negedge clk);
    chk("pe_3", 64'(proto3), 64'(1));

    // Reset in the middle of WAIT
    force_val = 1'b0;
    data3[1]  = 4'h3;
    valid3    = 3'b010;
    do_token(1, 1'b0, "rw");
    chk("rw_nz", 64'(out3 != 8'h00), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("rw_out0", 64'(out3), 64'(0));
    chk("rw_rdy0", 64'(ready3), 64'(0));
    chk("rw_flags", 64'({busy3, timeout3, proto3}), 64'(0));
    repeat (15) @(negedge clk);
    force_mode = 1'b0;
    data3[1]   = 4'h5;
    rst        = 1'b0;
    do_token(1, 1'b1, "post");
    valid3 = 3'b000;
    chk("post_out", 64'(out3), 64'(8'h66));
    chk("post_proto", 64'(proto3), 64'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
